i2c_slave_regfile: RTL and testbench

- Synthesizable, parametrised I2C slave with an internal register file; successor to the behavioural slave model.
- Sits on the shared SDA/SCL bus beside the master in the verification top and in future SoC integrations.
- Oversamples SCL/SDA on the I2C core clock.
- Supports:
  - 7-bit address match.
  - Register-pointer writes and burst writes.
  - Burst reads, including after a repeated START.
  - Pointer auto-increment with wrap.
  - NACK on address mismatch and on an out-of-range register index.

---
 rtl/i2c_slave_regfile.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C slave with an internal 8-bit register file, 7-bit addressing, pointer auto-increment and
// burst read/write. SCL/SDA are oversampled and synchronised on the core clock.
`timescale 1ns/1ps
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned MEM_DEPTH   = 16,
  parameter int unsigned PTR_W       = $clog2(MEM_DEPTH),
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i2c_core_clock_i,
  input  logic             preset_n_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe_o,
  output logic             busy_o,
  output logic             wr_valid_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic [PTR_W-1:0] ptr_o
);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StAddr     = 4'd1;
  localparam logic [3:0] StAddrAck  = 4'd2;
  localparam logic [3:0] StReg      = 4'd3;
  localparam logic [3:0] StWdata    = 4'd4;
  localparam logic [3:0] StDataAck  = 4'd5;
  localparam logic [3:0] StRdata    = 4'd6;
  localparam logic [3:0] StRdataAck = 4'd7;
  localparam logic [3:0] StIgnore   = 4'd8;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             sda_oe_q, sda_oe_d, busy_q, busy_d, wr_valid_q, wr_valid_d;
  logic             mem_we;
  logic [7:0]       mem_q [MEM_DEPTH];
  logic [7:0]       rd_byte;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rd_byte   = mem_q[ptr_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
    if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = StAddr;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      // Byte reception is shared by the three receiving states.
      if (scl_rise && cnt_q != 4'd8 &&
          (state_q == StAddr || state_q == StReg || state_q == StWdata)) begin
        shift_d = {shift_q[6:0], sda_s};
        cnt_d   = cnt_q + 4'd1;
      end
      case (state_q)
        StAddr: begin
          if (scl_fall && cnt_q == 4'd8) begin
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d  = StAddrAck;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = StIgnore;
              busy_d  = 1'b0;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (shift_q[0]) begin
              state_d  = StRdata;
              sda_oe_d = ~rd_byte[7];
              shift_d  = {rd_byte[6:0], 1'b0};
              cnt_d    = 4'd1;
            end else begin
              state_d  = StReg;
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
            end
          end
        end
        StReg: begin
          if (scl_fall && cnt_q == 4'd8) begin
            if ({24'd0, shift_q} < MEM_DEPTH) begin
              ptr_d    = shift_q[PTR_W-1:0];
              sda_oe_d = 1'b1;
              state_d  = StDataAck;
            end else begin
              state_d = StIgnore;
              busy_d  = 1'b0;
            end
          end
        end
        StWdata: begin
          if (scl_fall && cnt_q == 4'd8) begin
            mem_we     = 1'b1;
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = shift_q;
            ptr_d      = ptr_q + 1'b1;
            sda_oe_d   = 1'b1;
            state_d    = StDataAck;
          end
        end
        StDataAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = StWdata;
          end
        end
        StRdata: begin
          // cnt_q == 0 marks a byte still to be loaded after a master ACK.
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_oe_d = ~rd_byte[7];
              shift_d  = {rd_byte[6:0], 1'b0};
              cnt_d    = 4'd1;
            end else if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = StRdataAck;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        StRdataAck: begin
          if (scl_rise) begin
            ptr_d = ptr_q + 1'b1;
            if (sda_s) begin
              state_d = StIgnore;
              busy_d  = 1'b0;
            end else begin
              state_d = StRdata;
              cnt_d   = 4'd0;
            end
          end
        end
        StIgnore: sda_oe_d = 1'b0;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i2c_core_clock_i) begin
    if (!preset_n_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge i2c_core_clock_i) begin
    if (!preset_n_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[ptr_q] <= shift_q;
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign busy_o     = busy_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign ptr_o      = ptr_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: behavioural bus master with write/read scoreboards.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

  localparam int Q = 40;  // quarter SCL period: 4 core clocks

  logic       clk = 1'b0;
  logic       rst_n, scl, sda_m, sda;
  logic       sda_oe, busy, wr_valid;
  logic [3:0] wr_addr, ptr;
  logic [7:0] wr_data;

  always #5 clk = ~clk;
  assign sda = sda_m & ~sda_oe;

  i2c_slave_regfile dut (
    .i2c_core_clock_i(clk),
    .preset_n_i      (rst_n),
    .scl_i           (scl),
    .sda_i           (sda),
    .sda_oe_o        (sda_oe),
    .busy_o          (busy),
    .wr_valid_o      (wr_valid),
    .wr_addr_o       (wr_addr),
    .wr_data_o       (wr_data),
    .ptr_o           (ptr)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] wr_q [$];
  logic [7:0]  rd_q [$];
  logic [11:0] wr_exp;
  logic        oe_seen, busy_seen, oe_prev;
  int          oe_hi_chg = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_valid) begin
      if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else begin
        wr_exp = wr_q.pop_front();
        check("wr_addr", {28'd0, wr_addr}, {28'd0, wr_exp[11:8]});
        check("wr_data", {24'd0, wr_data}, {24'd0, wr_exp[7:0]});
      end
    end
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (rst_n && scl && sda_oe !== oe_prev) oe_hi_chg++;
    oe_prev = sda_oe;
  end

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic ack;
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    end
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; ack = sda; #Q; scl = 1'b0; #Q;
    check(tag, {31'd0, ack}, {31'd0, exp_ack});
  endtask

  task automatic rd_expect(input logic [7:0] exp, input logic nack);
    logic [7:0] b;
    rd_q.push_back(exp);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1; #Q; b[i] = sda; #Q; scl = 1'b0;
    end
    #Q; sda_m = nack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q; sda_m = 1'b1;
    check("rd_data", {24'd0, b}, {24'd0, rd_q.pop_front()});
  endtask

  task automatic wr_burst(input logic [7:0] reg_i, input logic [7:0] d0, input logic [7:0] d1);
    i2c_start();
    write_byte(8'hA0, 1'b0, "ack_addr");
    write_byte(reg_i, 1'b0, "ack_reg");
    wr_q.push_back({reg_i[3:0], d0});
    write_byte(d0, 1'b0, "ack_d0");
    wr_q.push_back({reg_i[3:0] + 4'd1, d1});
    write_byte(d1, 1'b0, "ack_d1");
    i2c_stop();
  endtask

  task automatic rd_setup(input logic [7:0] reg_i);
    i2c_start();
    write_byte(8'hA0, 1'b0, "ack_addr");
    write_byte(reg_i, 1'b0, "ack_reg");
    i2c_start();
    write_byte(8'hA1, 1'b0, "ack_addr_rd");
  endtask

  initial begin
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; oe_prev = 1'b0;
    oe_seen = 1'b0; busy_seen = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_ptr", {28'd0, ptr}, 32'd0);
    check("rst_wr_addr_data", {20'd0, wr_addr, wr_data}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Burst write with busy observed mid-transfer.
    i2c_start();
    write_byte(8'hA0, 1'b0, "ack_addr");
    check("busy_mid", {31'd0, busy}, 32'd1);
    write_byte(8'h03, 1'b0, "ack_reg");
    wr_q.push_back({4'h3, 8'hA5});
    write_byte(8'hA5, 1'b0, "ack_d0");
    wr_q.push_back({4'h4, 8'h5A});
    write_byte(8'h5A, 1'b0, "ack_d1");
    i2c_stop();
    #(2*Q);
    check("wr_ptr", {28'd0, ptr}, 32'd5);
    check("busy_after_stop", {31'd0, busy}, 32'd0);

    // Random read via repeated START.
    rd_setup(8'h03);
    rd_expect(8'hA5, 1'b0);
    rd_expect(8'h5A, 1'b1);
    check("oe_after_nack", {31'd0, sda_oe}, 32'd0);
    i2c_stop();
    #(2*Q);
    check("rd_ptr", {28'd0, ptr}, 32'd5);

    // Pointer wrap on write and read.
    wr_burst(8'h0F, 8'h11, 8'h22);
    #(2*Q);
    check("wrap_wr_ptr", {28'd0, ptr}, 32'd1);
    rd_setup(8'h0F);
    rd_expect(8'h11, 1'b0);
    rd_expect(8'h22, 1'b1);
    i2c_stop();
    #(2*Q);
    check("wrap_rd_ptr", {28'd0, ptr}, 32'd1);

    // Address mismatch: bus must stay untouched.
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, 1'b1, "nack_addr");
    write_byte(8'h01, 1'b1, "nack_mm_reg");
    write_byte(8'h99, 1'b1, "nack_mm_data");
    i2c_stop();
    #(2*Q);
    check("mm_oe_seen", {31'd0, oe_seen}, 32'd0);
    check("mm_busy_seen", {31'd0, busy_seen}, 32'd0);

    // Out-of-range register index.
    i2c_start();
    write_byte(8'hA0, 1'b0, "ack_addr");
    write_byte(8'h10, 1'b1, "nack_oor_reg");
    write_byte(8'h55, 1'b1, "nack_oor_data");
    i2c_stop();
    #(2*Q);
    check("oor_ptr", {28'd0, ptr}, 32'd1);
    rd_setup(8'h0F);
    rd_expect(8'h11, 1'b0);
    rd_expect(8'h22, 1'b0);
    rd_expect(8'h00, 1'b1);
    i2c_stop();
    #(2*Q);

    // Reset while the slave drives the first (zero) bit of 8'h5A.
    rd_setup(8'h04);
    check("rst_pre_oe", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_oe", {31'd0, sda_oe}, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_mid_ptr", {28'd0, ptr}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    i2c_stop();
    wr_burst(8'h02, 8'h77, 8'h88);
    #(2*Q);
    check("post_rst_ptr", {28'd0, ptr}, 32'd4);
    rd_setup(8'h0F);
    rd_expect(8'h00, 1'b0);
    rd_expect(8'h00, 1'b0);
    rd_expect(8'h00, 1'b0);
    rd_expect(8'h77, 1'b0);
    rd_expect(8'h88, 1'b1);
    i2c_stop();
    #(2*Q);

    check("wr_pending", wr_q.size(), 32'd0);
    check("oe_change_scl_high", oe_hi_chg, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
